// File: rtl/elelock_ctrl.sv
// Electronic-lock sequencer: collects keypad digits, checks them against the code
// and runs the open-hold and lockout timers. ELELOCK_CODE_CHANGE_EN enables code re-entry while open.
module elelock_ctrl #(
    parameter int unsigned NDIGIT        = 4,
    parameter logic [15:0] INIT_CODE     = 16'h1234,
    parameter int unsigned OPEN_TICKS    = 160,
    parameter int unsigned LOCKOUT_TICKS = 320,
    parameter int unsigned MAX_FAIL      = 3
) (
    input  logic        ck,
    input  logic        reset,
    input  logic        hz32,
    input  logic [3:0]  keycode,
    input  logic        keyenbl,
    output logic        lock,
    output logic        open_led,
    output logic        alarm,
    output logic [15:0] dispbuf,
    output logic [1:0]  state
);

    localparam int unsigned TMAX = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS : LOCKOUT_TICKS;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned CW   = $clog2(NDIGIT + 1);
    localparam int unsigned DW   = 4 * NDIGIT;

    localparam logic [TW-1:0] OPEN_LAST    = TW'(OPEN_TICKS - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_TICKS - 1);
    localparam logic [CW-1:0] CNT_FULL     = CW'(NDIGIT);
    localparam logic [FW-1:0] FAIL_SAT     = FW'(MAX_FAIL);
    localparam logic [3:0]    KEY_STAR     = 4'd10;
    localparam logic [3:0]    KEY_HASH     = 4'd11;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'b00,
        ST_OPEN    = 2'b01,
        ST_LOCKOUT = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   buf_q, buf_d;
    logic [15:0]   code_q;
    logic          keyenbl_prev, hz32_prev;
    logic          lock_d, open_led_d, alarm_d;
    logic          do_shift, do_clear;

    logic key_evt, tick, digit_evt, star_evt, hash_evt, entry_ok, match;

    // Single-cycle events from the rising edges of the slow inputs
    assign key_evt   = keyenbl & ~keyenbl_prev;
    assign tick      = hz32 & ~hz32_prev;
    assign digit_evt = key_evt && (keycode <= 4'd9);
    assign star_evt  = key_evt && (keycode == KEY_STAR);
    assign hash_evt  = key_evt && (keycode == KEY_HASH);
    assign entry_ok  = (cnt_q == CNT_FULL) && !ovf_q;
    assign match     = entry_ok && (buf_q[DW-1:0] == code_q[DW-1:0]);

`ifdef ELELOCK_CODE_CHANGE_EN
    logic [15:0] code_d;

    always_ff @(posedge ck) begin
        if (reset) code_q <= INIT_CODE;
        else       code_q <= code_d;
    end
`else
    assign code_q = INIT_CODE;
`endif

    // State register and all registered outputs
    always_ff @(posedge ck) begin
        if (reset) begin
            state_q      <= ST_LOCKED;
            timer_q      <= '0;
            fail_q       <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            buf_q        <= '0;
            keyenbl_prev <= 1'b0;
            hz32_prev    <= 1'b0;
            lock         <= 1'b1;
            open_led     <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fail_q       <= fail_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            buf_q        <= buf_d;
            keyenbl_prev <= keyenbl;
            hz32_prev    <= hz32;
            lock         <= lock_d;
            open_led     <= open_led_d;
            alarm        <= alarm_d;
        end
    end

    // Next-state, timer, counter and buffer logic
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        buf_d    = buf_q;
        do_shift = 1'b0;
        do_clear = 1'b0;
`ifdef ELELOCK_CODE_CHANGE_EN
        code_d   = code_q;
`endif

        case (state_q)
            ST_LOCKED: begin
                if (digit_evt) begin
                    do_shift = 1'b1;
                end else if (star_evt) begin
                    do_clear = 1'b1;
                end else if (hash_evt) begin
                    do_clear = 1'b1;
                    if (match) begin
                        state_d = ST_OPEN;
                        timer_d = '0;
                        fail_d  = '0;
                    end else if (32'(fail_q) + 32'd1 >= MAX_FAIL) begin
                        state_d = ST_LOCKOUT;
                        timer_d = '0;
                        fail_d  = FAIL_SAT;
                    end else begin
                        fail_d  = fail_q + FW'(1);
                    end
                end
            end

            ST_OPEN: begin
                // Close wins over any key arriving with the expiring tick
                if (star_evt || (tick && timer_q == OPEN_LAST)) begin
                    state_d  = ST_LOCKED;
                    timer_d  = '0;
                    do_clear = 1'b1;
                end else begin
                    if (tick) timer_d = timer_q + TW'(1);
`ifdef ELELOCK_CODE_CHANGE_EN
                    if (digit_evt) begin
                        do_shift = 1'b1;
                    end else if (hash_evt) begin
                        do_clear = 1'b1;
                        if (entry_ok) begin
                            code_d  = buf_q;
                            timer_d = '0;
                        end
                    end
`endif
                end
            end

            ST_LOCKOUT: begin
                do_clear = 1'b1;
                if (tick) begin
                    if (timer_q == LOCKOUT_LAST) begin
                        state_d = ST_LOCKED;
                        timer_d = '0;
                        fail_d  = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d  = ST_LOCKED;
                timer_d  = '0;
                do_clear = 1'b1;
            end
        endcase

        if (do_clear) begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (do_shift) begin
            buf_d = {buf_q[11:0], keycode};
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + CW'(1);
        end

        lock_d     = (state_d != ST_OPEN);
        open_led_d = (state_d == ST_OPEN);
        alarm_d    = (state_d == ST_LOCKOUT);
    end

    assign dispbuf = buf_q;
    assign state   = state_q;

endmodule

// File: tb/tb_elelock_ctrl.sv
// Directed bench for elelock_ctrl with short timers; the code-change scenario
// follows ELELOCK_CODE_CHANGE_EN.
module tb_elelock_ctrl;

    logic        ck = 1'b0;
    logic        reset;
    logic        hz32;
    logic [3:0]  keycode;
    logic        keyenbl;
    logic        lock, open_led, alarm;
    logic [15:0] dispbuf;
    logic [1:0]  state;

    int chk_cnt = 0;
    int err_cnt = 0;

    elelock_ctrl #(
        .NDIGIT(4), .INIT_CODE(16'h1234),
        .OPEN_TICKS(4), .LOCKOUT_TICKS(6), .MAX_FAIL(3)
    ) dut (
        .ck(ck), .reset(reset), .hz32(hz32), .keycode(keycode), .keyenbl(keyenbl),
        .lock(lock), .open_led(open_led), .alarm(alarm), .dispbuf(dispbuf), .state(state)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge ck);
        keycode = k;
        keyenbl = 1'b1;
        @(negedge ck);
        keyenbl = 1'b0;
        @(negedge ck);
    endtask

    task automatic enter(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
        press(4'd11);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ck);
            hz32 = 1'b1;
            @(negedge ck);
            hz32 = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        reset = 1'b1;
        @(negedge ck);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        hz32    = 1'b0;
        keycode = 4'd0;
        keyenbl = 1'b0;
        repeat (2) @(negedge ck);
        reset = 1'b0;

        check("rst_state", 32'(state), 32'h0);
        check("rst_lock", 32'(lock), 32'h1);
        check("rst_open", 32'(open_led), 32'h0);
        check("rst_alarm", 32'(alarm), 32'h0);
        check("rst_disp", 32'(dispbuf), 32'h0);

        // Correct code opens, open timer expires on the 4th tick
        press(4'd1); press(4'd2); press(4'd3);
        check("disp_123", 32'(dispbuf), 32'h0123);
        press(4'd4);
        check("disp_1234", 32'(dispbuf), 32'h1234);
        @(negedge ck);
        keycode = 4'd11;
        keyenbl = 1'b1;
        @(negedge ck);
        check("open_state", 32'(state), 32'h1);
        check("open_lock", 32'(lock), 32'h0);
        check("open_led", 32'(open_led), 32'h1);
        check("open_disp", 32'(dispbuf), 32'h0);
        keyenbl = 1'b0;
        @(negedge ck);
        tick_n(3);
        check("open_3tick", 32'(state), 32'h1);
        tick_n(1);
        check("expire_state", 32'(state), 32'h0);
        check("expire_lock", 32'(lock), 32'h1);
        check("expire_led", 32'(open_led), 32'h0);

        // Two failures, '*' and ignored inputs, third failure locks out
        press(4'd1); press(4'd2); press(4'd11);
        check("short_fail", 32'(state), 32'h0);
        enter(16'h9999);
        check("wrong_fail", 32'(state), 32'h0);
        press(4'd1); press(4'd2);
        check("disp_12", 32'(dispbuf), 32'h0012);
        press(4'd10);
        check("star_clear", 32'(dispbuf), 32'h0);
        tick_n(2);
        check("locked_tick", 32'(state), 32'h0);
        press(4'd12);
        check("key12_disp", 32'(dispbuf), 32'h0);
        check("key12_state", 32'(state), 32'h0);
        enter(16'h5555);
        check("lockout_state", 32'(state), 32'h2);
        check("lockout_alarm", 32'(alarm), 32'h1);
        check("lockout_lock", 32'(lock), 32'h1);

        // Keys ignored in lockout, exit after 6 ticks
        press(4'd1); press(4'd2);
        check("lockout_disp", 32'(dispbuf), 32'h0);
        press(4'd3); press(4'd4); press(4'd11);
        check("lockout_key", 32'(state), 32'h2);
        tick_n(5);
        check("lockout_5tick", 32'(state), 32'h2);
        tick_n(1);
        check("unlock_state", 32'(state), 32'h0);
        check("unlock_alarm", 32'(alarm), 32'h0);
        enter(16'h1234);
        check("reopen", 32'(state), 32'h1);
        press(4'd10);
        check("star_close", 32'(state), 32'h0);
        check("star_close_lock", 32'(lock), 32'h1);

        // Five digits overflow and count as a failure
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        check("ovf_disp", 32'(dispbuf), 32'h2345);
        press(4'd11);
        check("ovf_fail", 32'(state), 32'h0);
        enter(16'h5555);
        check("ovf_fail2", 32'(state), 32'h0);
        enter(16'h5555);
        check("ovf_lockout", 32'(state), 32'h2);
        do_reset();
        check("rst_mid_state", 32'(state), 32'h0);
        check("rst_mid_alarm", 32'(alarm), 32'h0);

        // Held key gives exactly one event
        @(negedge ck);
        keycode = 4'd7;
        keyenbl = 1'b1;
        repeat (50) @(negedge ck);
        keyenbl = 1'b0;
        @(negedge ck);
        check("hold_disp", 32'(dispbuf), 32'h0007);
        press(4'd10);

        // '*' together with the expiring tick
        enter(16'h1234);
        check("sim_open", 32'(state), 32'h1);
        tick_n(3);
        check("sim_lock_pre", 32'(lock), 32'h0);
        @(negedge ck);
        keycode = 4'd10;
        keyenbl = 1'b1;
        hz32    = 1'b1;
        @(negedge ck);
        keyenbl = 1'b0;
        hz32    = 1'b0;
        check("sim_state", 32'(state), 32'h0);
        check("sim_lock", 32'(lock), 32'h1);
        tick_n(1);
        check("sim_stable", 32'(state), 32'h0);
        check("sim_lock_stable", 32'(lock), 32'h1);

`ifdef ELELOCK_CODE_CHANGE_EN
        // Code change while open, reverted by reset
        do_reset();
        enter(16'h1234);
        check("cc_open", 32'(state), 32'h1);
        press(4'd4); press(4'd3);
        check("cc_disp", 32'(dispbuf), 32'h0043);
        press(4'd2); press(4'd1); press(4'd11);
        check("cc_load_state", 32'(state), 32'h1);
        check("cc_load_disp", 32'(dispbuf), 32'h0);
        press(4'd10);
        enter(16'h4321);
        check("cc_new_opens", 32'(state), 32'h1);
        press(4'd10);
        enter(16'h1234);
        check("cc_old_fails", 32'(state), 32'h0);
        do_reset();
        enter(16'h1234);
        check("cc_revert", 32'(state), 32'h1);
        press(4'd10);
`else
        // Digits and '#' are ignored while open
        do_reset();
        enter(16'h1234);
        check("nc_open", 32'(state), 32'h1);
        press(4'd4); press(4'd3);
        check("nc_disp", 32'(dispbuf), 32'h0);
        press(4'd2); press(4'd1); press(4'd11);
        check("nc_state", 32'(state), 32'h1);
        press(4'd10);
        enter(16'h4321);
        check("nc_code_const", 32'(state), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", chk_cnt, 0);
        $fatal(1, "timeout");
    end

endmodule
